// File: rtl/serial_tx_fifo.sv
// rtl/serial_tx_fifo.sv - first-word fall-through byte FIFO feeding serial_transmitter
// Optional drop counter output enabled by SERIAL_TX_FIFO_DROP_COUNT_EN.
module serial_tx_fifo #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 16,
  localparam int ADDR_WIDTH = $clog2(DEPTH)
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  wr_en,
  output logic                  full,
  output logic                  empty,
  output logic [ADDR_WIDTH:0]   count,
  output logic [DATA_WIDTH-1:0] tx_data,
  output logic                  tx_data_available,
  input  logic                  tx_ready,
  output logic                  overflow,
  input  logic                  overflow_clear
`ifdef SERIAL_TX_FIFO_DROP_COUNT_EN
  ,
  output logic [7:0]            drop_count
`endif
);

  localparam logic [ADDR_WIDTH:0] PtrOne     = 1;
  localparam logic [ADDR_WIDTH:0] DepthCount = DEPTH;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  logic [ADDR_WIDTH:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_WIDTH:0] count_q, count_d;
  logic                overflow_q, overflow_d;
  logic                do_push, do_pop, do_drop;

  assign full              = (count_q == DepthCount);
  assign empty             = (count_q == '0);
  assign count             = count_q;
  assign tx_data_available = !empty;
  assign tx_data           = mem_q[rd_ptr_q[ADDR_WIDTH-1:0]];
  assign overflow          = overflow_q;

  // Full is taken from registered occupancy only, so a same-cycle pop never frees room.
  assign do_push = wr_en && !full;
  assign do_drop = wr_en && full;
  assign do_pop  = tx_data_available && tx_ready;

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    if (do_push) wr_ptr_d = wr_ptr_q + PtrOne;
    if (do_pop)  rd_ptr_d = rd_ptr_q + PtrOne;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + PtrOne;
      2'b01:   count_d = count_q - PtrOne;
      default: count_d = count_q;
    endcase
    if (do_drop)             overflow_d = 1'b1;
    else if (overflow_clear) overflow_d = 1'b0;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  always_ff @(posedge clock) begin
    if (do_push) mem_q[wr_ptr_q[ADDR_WIDTH-1:0]] <= wr_data;
  end

`ifdef SERIAL_TX_FIFO_DROP_COUNT_EN
  logic [7:0] drop_count_q, drop_count_d;

  // An increment on the clearing cycle restarts the count at one.
  always_comb begin
    drop_count_d = drop_count_q;
    if (do_drop) begin
      if (overflow_clear)              drop_count_d = 8'd1;
      else if (drop_count_q != 8'hFF)  drop_count_d = drop_count_q + 8'd1;
    end else if (overflow_clear) begin
      drop_count_d = 8'd0;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) drop_count_q <= 8'd0;
    else          drop_count_q <= drop_count_d;
  end

  assign drop_count = drop_count_q;
`endif

endmodule

// File: tb/tb_serial_tx_fifo.sv
// tb/tb_serial_tx_fifo.sv - directed self-checking bench for serial_tx_fifo
module tb_serial_tx_fifo;

  logic       clock = 1'b0;
  logic       reset_n;
  logic [7:0] wr_data;
  logic       wr_en;
  logic       full;
  logic       empty;
  logic [4:0] count;
  logic [7:0] tx_data;
  logic       tx_data_available;
  logic       tx_ready;
  logic       overflow;
  logic       overflow_clear;
`ifdef SERIAL_TX_FIFO_DROP_COUNT_EN
  logic [7:0] drop_count;
`endif

  int checks   = 0;
  int failures = 0;

  always #5 clock = ~clock;

  serial_tx_fifo #(.DATA_WIDTH(8), .DEPTH(16)) dut (
    .clock             (clock),
    .reset_n           (reset_n),
    .wr_data           (wr_data),
    .wr_en             (wr_en),
    .full              (full),
    .empty             (empty),
    .count             (count),
    .tx_data           (tx_data),
    .tx_data_available (tx_data_available),
    .tx_ready          (tx_ready),
    .overflow          (overflow),
    .overflow_clear    (overflow_clear)
`ifdef SERIAL_TX_FIFO_DROP_COUNT_EN
    ,
    .drop_count        (drop_count)
`endif
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic fill(input logic [7:0] base);
    wr_en = 1'b1;
    for (int i = 0; i < 16; i++) begin
      wr_data = base + 8'(i);
      step();
    end
    wr_en = 1'b0;
  endtask

  initial begin
    reset_n = 1'b0; wr_data = 8'h00; wr_en = 1'b0; tx_ready = 1'b0; overflow_clear = 1'b0;
    step(); step();
    reset_n = 1'b1;
    step();
    check("rst_count", 32'(count), 0);
    check("rst_empty", 32'(empty), 1);
    check("rst_full", 32'(full), 0);
    check("rst_avail", 32'(tx_data_available), 0);
    check("rst_overflow", 32'(overflow), 0);
`ifdef SERIAL_TX_FIFO_DROP_COUNT_EN
    check("rst_drop_count", 32'(drop_count), 0);
`endif

    // single byte latency and pop
    wr_data = 8'h48; wr_en = 1'b1;
    step();
    wr_en = 1'b0;
    check("one_data", 32'(tx_data), 32'h48);
    check("one_avail", 32'(tx_data_available), 1);
    check("one_count", 32'(count), 1);
    tx_ready = 1'b1;
    step();
    tx_ready = 1'b0;
    check("one_pop_count", 32'(count), 0);
    check("one_pop_empty", 32'(empty), 1);
    tx_ready = 1'b1;
    step();
    tx_ready = 1'b0;
    check("ready_on_empty_count", 32'(count), 0);

    // fill, drop, set-beats-clear, drain in order
    fill(8'h00);
    check("fill_full", 32'(full), 1);
    check("fill_count", 32'(count), 16);
    wr_data = 8'hAA; wr_en = 1'b1;
    step();
    wr_en = 1'b0;
    check("drop_overflow", 32'(overflow), 1);
    check("drop_count16", 32'(count), 16);
    overflow_clear = 1'b1;
    step();
    overflow_clear = 1'b0;
    check("clear_overflow", 32'(overflow), 0);
    wr_en = 1'b1; overflow_clear = 1'b1;
    step();
    wr_en = 1'b0; overflow_clear = 1'b0;
    check("set_wins_overflow", 32'(overflow), 1);
    tx_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      check($sformatf("drain_%0d", i), 32'(tx_data), 32'(i));
      step();
    end
    tx_ready = 1'b0;
    check("drain_empty", 32'(empty), 1);
    overflow_clear = 1'b1;
    step();
    overflow_clear = 1'b0;

    // pop on full with a write: pop happens, write dropped
    fill(8'h30);
    wr_data = 8'h55; wr_en = 1'b1; tx_ready = 1'b1;
    step();
    wr_en = 1'b0; tx_ready = 1'b0;
    check("popfull_count", 32'(count), 15);
    check("popfull_overflow", 32'(overflow), 1);
    check("popfull_head", 32'(tx_data), 32'h31);
    tx_ready = 1'b1;
    for (int i = 1; i < 16; i++) begin
      check($sformatf("popfull_drain_%0d", i), 32'(tx_data), 32'h30 + 32'(i));
      step();
    end
    tx_ready = 1'b0;
    check("popfull_empty", 32'(empty), 1);
    overflow_clear = 1'b1;
    step();
    overflow_clear = 1'b0;
    check("popfull_cleared", 32'(overflow), 0);

    // streaming with pointer wrap
    tx_ready = 1'b1; wr_en = 1'b1;
    for (int k = 0; k < 40; k++) begin
      wr_data = 8'h80 + 8'(k);
      step();
      check($sformatf("stream_data_%0d", k), 32'(tx_data), 32'h80 + 32'(k));
      check($sformatf("stream_count_%0d", k), 32'(count), 1);
    end
    wr_en = 1'b0;
    step();
    tx_ready = 1'b0;
    check("stream_end_empty", 32'(empty), 1);

    // asynchronous reset mid-stream
    wr_en = 1'b1;
    for (int i = 0; i < 5; i++) begin
      wr_data = 8'h60 + 8'(i);
      step();
    end
    wr_en = 1'b0;
    check("pre_reset_count", 32'(count), 5);
    #2;
    reset_n = 1'b0;
    #1;
    check("async_avail", 32'(tx_data_available), 0);
    check("async_count", 32'(count), 0);
    check("async_empty", 32'(empty), 1);
    step();
    reset_n = 1'b1;
    step();
    wr_data = 8'h21; wr_en = 1'b1;
    step();
    wr_en = 1'b0;
    check("post_reset_data", 32'(tx_data), 32'h21);
    check("post_reset_count", 32'(count), 1);
    tx_ready = 1'b1;
    step();
    tx_ready = 1'b0;
    check("post_reset_empty", 32'(empty), 1);

`ifdef SERIAL_TX_FIFO_DROP_COUNT_EN
    fill(8'h10);
    wr_en = 1'b1; wr_data = 8'hEE;
    for (int i = 0; i < 300; i++) step();
    wr_en = 1'b0;
    check("dc_saturate", 32'(drop_count), 255);
    check("dc_overflow", 32'(overflow), 1);
    overflow_clear = 1'b1;
    step();
    overflow_clear = 1'b0;
    check("dc_clear", 32'(drop_count), 0);
    check("dc_overflow_clear", 32'(overflow), 0);
    wr_en = 1'b1; overflow_clear = 1'b1;
    step();
    wr_en = 1'b0; overflow_clear = 1'b0;
    check("dc_inc_wins", 32'(drop_count), 1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
